// File: rtl/mod16_timer_arbiter.sv
// Round-robin arbiter sharing one mod-2**CNT_W tick counter among NUM_REQ requesters.
// IDLE: arbitrate | RUN: count owner's interval | DONE: one-cycle completion pulse
`timescale 1ns/1ps
module mod16_timer_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int CNT_W   = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*CNT_W-1:0] req_len,
  input  logic                     tick_en,
  output logic [NUM_REQ-1:0]       grant,
  output logic [NUM_REQ-1:0]       done,
  output logic                     busy,
  output logic [CNT_W-1:0]         count
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t             state_q;
  logic [NUM_REQ-1:0] grant_q, done_q;
  logic               busy_q;
  logic [CNT_W-1:0]   count_q, len_q;
  logic [IDX_W-1:0]   rr_ptr_q, owner_q;

  logic [CNT_W-1:0]   len_arr [NUM_REQ];
  logic               arb_found;
  logic [IDX_W-1:0]   arb_idx, cand, next_ptr;
  logic [CNT_W-1:0]   term;
  logic [NUM_REQ-1:0] arb_onehot;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      len_arr[i] = req_len[i*CNT_W +: CNT_W];
    end
  end

  // First pending request at or above rr_ptr, wrapping around.
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = '0;
    cand      = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = IDX_W'((int'(rr_ptr_q) + i) % NUM_REQ);
      if (!arb_found && req[cand]) begin
        arb_found = 1'b1;
        arb_idx   = cand;
      end
    end
  end

  assign arb_onehot = {{(NUM_REQ-1){1'b0}}, 1'b1} << arb_idx;
  assign next_ptr   = (owner_q == IDX_W'(NUM_REQ-1)) ? '0 : owner_q + 1'b1;
  // A latched length of 0 gives term = all ones, i.e. a full 2**CNT_W interval.
  assign term       = len_q - CNT_W'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      grant_q  <= '0;
      done_q   <= '0;
      busy_q   <= 1'b0;
      count_q  <= '0;
      len_q    <= '0;
      rr_ptr_q <= '0;
      owner_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q  <= '0;
          count_q <= '0;
          if (arb_found) begin
            state_q <= S_RUN;
            grant_q <= arb_onehot;
            busy_q  <= 1'b1;
            owner_q <= arb_idx;
            len_q   <= len_arr[arb_idx];
          end else begin
            grant_q <= '0;
            busy_q  <= 1'b0;
          end
        end
        S_RUN: begin
          if (!req[owner_q]) begin
            state_q  <= S_IDLE;
            grant_q  <= '0;
            busy_q   <= 1'b0;
            count_q  <= '0;
            rr_ptr_q <= next_ptr;
          end else if (tick_en) begin
            if (count_q == term) begin
              state_q <= S_DONE;
              count_q <= '0;
              done_q  <= grant_q;
            end else begin
              count_q <= count_q + CNT_W'(1);
            end
          end
        end
        S_DONE: begin
          state_q  <= S_IDLE;
          done_q   <= '0;
          grant_q  <= '0;
          busy_q   <= 1'b0;
          rr_ptr_q <= next_ptr;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign grant = grant_q;
  assign done  = done_q;
  assign busy  = busy_q;
  assign count = count_q;

endmodule

// File: tb/tb_mod16_timer_arbiter.sv
// Directed bench for mod16_timer_arbiter: vector table plus hand-written multi-cycle sequences.
`timescale 1ns/1ps
module tb_mod16_timer_arbiter;

  logic        clk, reset, tick_en;
  logic [3:0]  req, grant, done, count;
  logic [15:0] req_len;
  logic        busy;
  int          total, bad, cyc;

  mod16_timer_arbiter #(.NUM_REQ(4), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .req(req), .req_len(req_len), .tick_en(tick_en),
    .grant(grant), .done(done), .busy(busy), .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [3:0]  req;
    logic [15:0] len;
    logic        te;
    logic [3:0]  grant;
    logic [3:0]  done;
    logic        busy;
    logic [3:0]  count;
  } vec_t;

  vec_t tbl [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string name, input logic [3:0] g, input logic [3:0] d,
                         input logic b, input logic [3:0] c);
    chk({name, ".grant"}, grant, g);
    chk({name, ".done"},  done,  d);
    chk({name, ".busy"},  busy,  b);
    chk({name, ".count"}, count, c);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Asserts reset away from the clock edge and checks the asynchronous clear.
  task automatic do_reset();
    #2;
    reset = 1'b1;
    #1;
    chk_all("reset", 4'b0000, 4'b0000, 1'b0, 4'd0);
    req = '0; req_len = '0; tick_en = 1'b0;
    step();
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int g0, last;
    total = 0; bad = 0; cyc = 0;
    reset = 1'b0; req = '0; req_len = '0; tick_en = 1'b0;

    // req_len changes to 1 mid-run must be ignored: L stays 5.
    tbl[0] = '{req:4'b0001, len:16'h0005, te:1'b1, grant:4'b0001, done:4'b0000, busy:1'b1, count:4'd0};
    tbl[1] = '{req:4'b0001, len:16'h0005, te:1'b1, grant:4'b0001, done:4'b0000, busy:1'b1, count:4'd1};
    tbl[2] = '{req:4'b0001, len:16'h0001, te:1'b1, grant:4'b0001, done:4'b0000, busy:1'b1, count:4'd2};
    tbl[3] = '{req:4'b0001, len:16'h0001, te:1'b1, grant:4'b0001, done:4'b0000, busy:1'b1, count:4'd3};
    tbl[4] = '{req:4'b0001, len:16'h0001, te:1'b1, grant:4'b0001, done:4'b0000, busy:1'b1, count:4'd4};
    tbl[5] = '{req:4'b0001, len:16'h0005, te:1'b1, grant:4'b0001, done:4'b0001, busy:1'b1, count:4'd0};
    tbl[6] = '{req:4'b0000, len:16'h0005, te:1'b1, grant:4'b0000, done:4'b0000, busy:1'b0, count:4'd0};
    tbl[7] = '{req:4'b0000, len:16'h0005, te:1'b1, grant:4'b0000, done:4'b0000, busy:1'b0, count:4'd0};

    #1;
    do_reset();

    // Single requester, L=5
    for (int i = 0; i < 8; i++) begin
      req = tbl[i].req; req_len = tbl[i].len; tick_en = tbl[i].te;
      step();
      chk_all($sformatf("t1.v%0d", i), tbl[i].grant, tbl[i].done, tbl[i].busy, tbl[i].count);
    end

    // L=0 means 16 ticks, count wraps 15 -> 0 (rr_ptr is 1 here, req[2] still found)
    req = 4'b0100; req_len = 16'h0000; tick_en = 1'b1;
    step();
    chk_all("t3.grant", 4'b0100, 4'b0000, 1'b1, 4'd0);
    for (int k = 1; k < 16; k++) begin
      step();
      chk($sformatf("t3.count%0d", k), count, k);
    end
    step();
    chk_all("t3.done", 4'b0100, 4'b0100, 1'b1, 4'd0);
    req = '0;
    step();
    chk_all("t3.idle", 4'b0000, 4'b0000, 1'b0, 4'd0);

    // Round robin over four requesters, L=2 each
    do_reset();
    req = 4'b1111; req_len = 16'h2222; tick_en = 1'b1;
    last = 0;
    for (int g = 0; g < 4; g++) begin
      step();
      chk_all($sformatf("t2.grant%0d", g), 4'(1 << g), 4'b0000, 1'b1, 4'd0);
      step();
      chk($sformatf("t2.count%0d", g), count, 1);
      step();
      chk_all($sformatf("t2.done%0d", g), 4'(1 << g), 4'(1 << g), 1'b1, 4'd0);
      if (g > 0) chk($sformatf("t2.spacing%0d", g), cyc - last, 4);
      last = cyc;
      req[g] = 1'b0;
      step();
      chk_all($sformatf("t2.idle%0d", g), 4'b0000, 4'b0000, 1'b0, 4'd0);
    end

    // Tick gating: L=6 with ticks on every other cycle
    do_reset();
    req = 4'b0001; req_len = 16'h0006; tick_en = 1'b0;
    step();
    chk_all("t4.grant", 4'b0001, 4'b0000, 1'b1, 4'd0);
    g0 = cyc;
    for (int k = 1; k <= 12; k++) begin
      tick_en = (k % 2 == 0);
      step();
      if (k < 12) begin
        chk($sformatf("t4.count%0d", k), count, k / 2);
        chk($sformatf("t4.nodone%0d", k), done, 0);
      end else begin
        chk_all("t4.done", 4'b0001, 4'b0001, 1'b1, 4'd0);
        chk("t4.latency", cyc - g0, 12);
      end
    end
    req = '0;
    step();
    chk_all("t4.idle", 4'b0000, 4'b0000, 1'b0, 4'd0);

    // Abort mid-run, then abort coinciding with the terminal tick
    do_reset();
    req = 4'b0110; req_len = 16'h0280; tick_en = 1'b1;
    step();
    chk_all("t5.grant1", 4'b0010, 4'b0000, 1'b1, 4'd0);
    for (int k = 1; k <= 3; k++) begin
      step();
      chk($sformatf("t5.count%0d", k), count, k);
    end
    req = 4'b0100;
    step();
    chk_all("t5.abort", 4'b0000, 4'b0000, 1'b0, 4'd0);
    step();
    chk_all("t5.grant2", 4'b0100, 4'b0000, 1'b1, 4'd0);
    step();
    chk("t5.count2", count, 1);
    req = '0;
    step();
    chk_all("t5.abort_term", 4'b0000, 4'b0000, 1'b0, 4'd0);
    step();
    chk_all("t5.quiet", 4'b0000, 4'b0000, 1'b0, 4'd0);

    // Reset mid-interval
    do_reset();
    req = 4'b0001; req_len = 16'h000a; tick_en = 1'b1;
    step();
    chk_all("t6.grant", 4'b0001, 4'b0000, 1'b1, 4'd0);
    for (int k = 1; k <= 7; k++) step();
    chk("t6.count7", count, 7);
    do_reset();
    step();
    chk_all("t6.postrst", 4'b0000, 4'b0000, 1'b0, 4'd0);
    req = 4'b1001; req_len = 16'h3003;
    step();
    chk_all("t6.rrptr0", 4'b0001, 4'b0000, 1'b1, 4'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
